gray_counter: RTL and testbench
===============================

# gray_counter

Parametrised up/down counter with simultaneous registered binary and Gray-code outputs, the sequential successor to the team's transmission-gate XOR primitive in the Counters library. The Gray output is the XOR of adjacent binary bits, computed from the next-state count and registered, so exactly one bit of `gray_out` changes per count step with no decode glitches. Intended for clock-domain-crossing pointers, position encoders and test stimulus in the Counters subsystem.

## Interface
- `WIDTH`, 4: counter width in bits; legal range 2..32.
- `WRAP`, 1: 1 = modulo-2^WIDTH wrap-around; 0 = saturate at terminal value.
- `RESET_VAL`, 0: binary value loaded on reset; must be < 2^WIDTH.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: count enable; one step per enabled cycle.
- `up_dn` input 1: direction; 1 = increment, 0 = decrement; sampled only when counting.
- `load` input 1: synchronous load strobe.
- `load_val` input WIDTH: binary value applied on `load`.
- `bin_out` output WIDTH: registered binary count.
- `gray_out` output WIDTH: registered Gray code of `bin_out`.
- `tc` output 1: registered terminal-count flag.

## Operation
- Single internal binary register `cnt`; `bin_out` = `cnt`.
- Priority per edge: `rst` > `load` > `en` > hold.
- `load` = 1: `cnt` <- `load_val`; `tc` <- 0; `en`, `up_dn` ignored.
- `en` = 1, `load` = 0, not at terminal: `cnt` <- `cnt` + 1 (`up_dn` = 1) or `cnt` - 1 (`up_dn` = 0); `tc` <- 0.
- Terminal: `cnt` = 2^WIDTH-1 while counting up, or `cnt` = 0 while counting down.
- At terminal with `en` = 1, `load` = 0: `tc` <- 1; `WRAP` = 1: `cnt` wraps (MAX->0 up, 0->MAX down); `WRAP` = 0: `cnt` holds.
- `en` = 0, `load` = 0: `cnt` holds; `tc` <- 0.
- Gray encoding: `gray[i]` = `b[i]` ^ `b[i+1]` for i < WIDTH-1; `gray[WIDTH-1]` = `b[WIDTH-1]`, where `b` is the next-state value of `cnt`; `gray_out` registered on the same edge as `cnt`, never derived combinationally from `bin_out`.
- Direction changes take effect on the next enabled edge; no dead cycle.
- Arithmetic is WIDTH bits unsigned; overflow/underflow only via the terminal rules above.

## Timing
- Reset (async assert, any time): `bin_out` = `RESET_VAL`, `gray_out` = Gray(`RESET_VAL`), `tc` = 0, immediately, without a clock edge.
- Reset release: first counting edge is the first rising `clk` with `rst` = 0; mid-count reset discards the count and the pending `tc`.
- Latency: `en`/`load` sampled at edge N; `bin_out`, `gray_out`, `tc` updated after edge N; all three always mutually consistent.
- `tc` is a one-cycle pulse per terminal event in WRAP mode; in saturate mode it stays high for every enabled cycle spent at the terminal value.
- Between any two consecutive enabled non-load edges, `gray_out` differs in exactly one bit, including across the wrap.
- `load` and `en` asserted together: load wins; no count step, `tc` = 0.

## Test plan
- Reset: WIDTH=4, RESET_VAL=5, assert `rst` mid-cycle -> `bin_out`=5, `gray_out`=4'b0111, `tc`=0 before next edge.
- Up-wrap: WRAP=1, from 0, `en`=1 `up_dn`=1 for 17 cycles -> sequence 1..15,0,1; `tc`=1 only in the cycle after 15->0; `gray_out` Hamming distance 1 every step.
- Down-wrap: from 2, `up_dn`=0, 3 enabled cycles -> 1, 0, 15; `tc`=1 only after the 0->15 step; `gray_out` at 15 = 4'b1000.
- Saturate: WRAP=0, load 14, count up 4 cycles -> 15,15,15,15; `tc`=0,1,1,1; then `up_dn`=0 one cycle -> 14, `tc`=0.
- Load priority: `load`=1, `en`=1, `load_val`=9 -> `bin_out`=9, `gray_out`=4'b1101, `tc`=0; `en`=0 next cycles -> holds 9.
- Reset mid-operation: counting up at 15 with `en`=1, assert `rst` before edge -> `tc` stays 0, `bin_out`=`RESET_VAL`; release, first enabled edge -> `RESET_VAL`+1.

Source files
------------

// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
//
// Up/down counter with registered binary and Gray-code outputs. The Gray value
// is encoded from the next-state count and captured on the same edge as the
// binary count. This keeps gray_out glitch-free, and gray_out changes in exactly
// one bit per count step. Suitable for clock-domain-crossing pointers.
//
// Parameters
//   WIDTH     : counter width in bits, 2..32
//   WRAP      : 1 = wrap modulo 2^WIDTH at the terminal value, 0 = saturate
//   RESET_VAL : binary value loaded by reset (must be < 2^WIDTH)
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   en       in   count enable, one step per enabled cycle
//   up_dn    in   1 = count up, 0 = count down (only looked at when counting)
//   load     in   synchronous load strobe; has priority over en
//   load_val in   value applied on load
//   bin_out  out  registered binary count
//   gray_out out  registered Gray code of bin_out
//   tc       out  registered terminal-count flag
// -----------------------------------------------------------------------------
module gray_counter #(
  parameter int          WIDTH     = 4,
  parameter bit          WRAP      = 1'b1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RST_BIN  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Gray bit i is the XOR of binary bits i and i+1. The MSB passes through.
  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    g[WIDTH-1] = b[WIDTH-1];
    for (int i = 0; i < WIDTH-1; i++) begin
      g[i] = b[i] ^ b[i+1];
    end
    return g;
  endfunction

  localparam logic [WIDTH-1:0] RST_GRAY = to_gray(RST_BIN);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] gray_q;
  logic             tc_q;
  logic             tc_nxt;
  logic             at_term;

  // The terminal value depends on the direction: MAX when counting up,
  // 0 when counting down.
  assign at_term = up_dn ? (cnt == CNT_MAX) : (cnt == CNT_ZERO);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    cnt_nxt = cnt;
    tc_nxt  = 1'b0;
    if (load) begin
      cnt_nxt = load_val;
    end else if (en) begin
      if (at_term) begin
        tc_nxt = 1'b1;
        if (WRAP) begin
          cnt_nxt = up_dn ? CNT_ZERO : CNT_MAX;
        end
      end else begin
        cnt_nxt = up_dn ? (cnt + CNT_ONE) : (cnt - CNT_ONE);
      end
    end
  end

  // Gray is encoded from cnt_nxt and registered on the same edge. Decoding it
  // from bin_out would add a combinational stage that could glitch.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so that every flop
    // samples pre-edge values, whatever order the simulator runs the blocks in.
    if (rst) begin
      cnt    <= RST_BIN;
      gray_q <= RST_GRAY;
      tc_q   <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      gray_q <= to_gray(cnt_nxt);
      tc_q   <= tc_nxt;
    end
  end

  assign bin_out  = cnt;
  assign gray_out = gray_q;
  assign tc       = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// -----------------------------------------------------------------------------
// tb_gray_counter
//
// Drives two 4-bit counters with shared inputs. One counter wraps and the other
// saturates, and both reset to 5. A reference model checks both counters on
// every falling edge. The model uses plain integer arithmetic: a step that
// leaves the range 0..15 is a terminal event. Directed steps also compare
// against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_gray_counter;

  localparam int W    = 4;
  localparam int RV   = 5;
  localparam int MODN = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         en = 1'b0;
  logic         up_dn = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] w_bin, w_gray, s_bin, s_gray;
  logic         w_tc, s_tc;

  int checks = 0;
  int errors = 0;

  gray_counter #(.WIDTH(W), .WRAP(1'b1), .RESET_VAL(RV)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .bin_out(w_bin), .gray_out(w_gray), .tc(w_tc)
  );

  gray_counter #(.WIDTH(W), .WRAP(1'b0), .RESET_VAL(RV)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .bin_out(s_bin), .gray_out(s_gray), .tc(s_tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model
  int m_w = RV, m_s = RV;
  bit t_w = 1'b0, t_s = 1'b0;
  bit counted = 1'b0;  // the previous edge was an enabled, non-load step

  function automatic void model_step(input int cur, input bit wrap,
                                     output int nxt, output bit term);
    int raw;
    term = 1'b0;
    nxt  = cur;
    if (load) begin
      nxt = int'(load_val);
    end else if (en) begin
      raw = up_dn ? cur + 1 : cur - 1;
      if (raw < 0 || raw >= MODN) begin
        term = 1'b1;
        nxt  = wrap ? (raw + MODN) % MODN : cur;
      end else begin
        nxt = raw;
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    int nw, ns;
    bit tw, ts;
    if (rst) begin
      m_w <= RV; m_s <= RV; t_w <= 1'b0; t_s <= 1'b0; counted <= 1'b0;
    end else begin
      model_step(m_w, 1'b1, nw, tw);
      model_step(m_s, 1'b0, ns, ts);
      m_w <= nw; m_s <= ns; t_w <= tw; t_s <= ts;
      counted <= en && !load;
    end
  end

  // Compare process
  logic [W-1:0] prev_wgray = '0;
  always @(negedge clk) begin
    check("wrap_bin",  w_bin,  m_w);
    check("wrap_gray", w_gray, m_w ^ (m_w >> 1));
    check("wrap_tc",   w_tc,   t_w);
    check("sat_bin",   s_bin,  m_s);
    check("sat_gray",  s_gray, m_s ^ (m_s >> 1));
    check("sat_tc",    s_tc,   t_s);
    if (counted) check("wrap_gray_hamming", $countones(w_gray ^ prev_wgray), 1);
    prev_wgray = w_gray;
  end

  task automatic step(input bit e, input bit u, input bit l, input int lv);
    @(negedge clk);
    en = e; up_dn = u; load = l; load_val = lv[W-1:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_bin",  w_bin,  5);
    check("rst_gray", w_gray, 4'b0111);
    check("rst_tc",   w_tc,   0);
    check("rst_sat_bin", s_bin, 5);
    @(negedge clk);
    rst = 1'b0;

    // Up-wrap from 0 for 17 enabled cycles.
    step(1'b0, 1'b1, 1'b1, 0);
    check("load0_bin", w_bin, 0);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b1, 1'b0, 0);
      check($sformatf("upwrap_bin_%0d", i), w_bin, (i + 1) % 16);
      check($sformatf("upwrap_tc_%0d", i),  w_tc,  (i == 15) ? 1 : 0);
    end

    // Down-wrap from 2.
    step(1'b0, 1'b0, 1'b1, 2);
    step(1'b1, 1'b0, 1'b0, 0);
    check("down_bin_a", w_bin, 1);
    check("down_tc_a",  w_tc,  0);
    step(1'b1, 1'b0, 1'b0, 0);
    check("down_bin_b", w_bin, 0);
    check("down_tc_b",  w_tc,  0);
    step(1'b1, 1'b0, 1'b0, 0);
    check("down_bin_c",  w_bin,  15);
    check("down_tc_c",   w_tc,   1);
    check("down_gray_c", w_gray, 4'b1000);

    // Saturate at 15, then reverse.
    step(1'b0, 1'b1, 1'b1, 14);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 0);
      check($sformatf("sat_bin_%0d", i), s_bin, 15);
      check($sformatf("sat_tc_%0d", i),  s_tc,  (i == 0) ? 0 : 1);
    end
    step(1'b1, 1'b0, 1'b0, 0);
    check("sat_rev_bin", s_bin, 14);
    check("sat_rev_tc",  s_tc,  0);

    // Load wins over en.
    step(1'b1, 1'b1, 1'b1, 9);
    check("ld_bin",  w_bin,  9);
    check("ld_gray", w_gray, 4'b1101);
    check("ld_tc",   w_tc,   0);
    check("ld_sat_bin", s_bin, 9);
    step(1'b0, 1'b1, 1'b0, 3);
    step(1'b0, 1'b0, 1'b0, 3);
    check("hold_bin", w_bin, 9);
    check("hold_tc",  w_tc,  0);

    // Reset while sitting at 15 about to wrap.
    step(1'b0, 1'b1, 1'b1, 14);
    step(1'b1, 1'b1, 1'b0, 0);
    check("pre_rst_bin", w_bin, 15);
    @(negedge clk);
    en = 1'b1; up_dn = 1'b1; load = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_bin",  w_bin,  5);
    check("midrst_gray", w_gray, 4'b0111);
    check("midrst_tc",   w_tc,   0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_bin", w_bin, 6);
    check("post_rst_tc",  w_tc,  0);
    step(1'b0, 1'b1, 1'b0, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
